// File: rtl/cpu_bus_arbiter_n.sv
// Purpose: arbitrates PORTS masters onto one shared CPU bus (fixed priority or round-robin).
// Latency: request to o_bus_request in 1 cycle; at least 4 cycles per transfer with a zero-wait slave.
// Backpressure: the granted port waits on i_bus_ready (or the optional timeout); others stay pending.
module cpu_bus_arbiter_n #(
  parameter int PORTS   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MODE    = 1,
  parameter int TIMEOUT = 0
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [PORTS-1:0]          i_request,
  input  logic [PORTS-1:0]          i_rw,
  input  logic [PORTS*ADDR_W-1:0]   i_address,
  input  logic [PORTS*DATA_W-1:0]   i_wdata,
  output logic [PORTS-1:0]          o_ready,
  output logic [PORTS-1:0]          o_error,
  output logic [PORTS*DATA_W-1:0]   o_rdata,
  output logic                      o_bus_rw,
  output logic                      o_bus_request,
  input  logic                      i_bus_ready,
  output logic [ADDR_W-1:0]         o_bus_address,
  input  logic [DATA_W-1:0]         i_bus_rdata,
  output logic [DATA_W-1:0]         o_bus_wdata,
  output logic                      o_busy,
  output logic [2:0]                o_grant
);

  // Counter only needs to reach TIMEOUT-1; keep at least one bit when timeout is disabled.
  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = TO_LAST[CNT_W-1:0];

  typedef enum logic [1:0] {IDLE, BUS, ACK} state_t;

  state_t                    state_q;
  logic [2:0]                grant_q;
  logic [2:0]                last_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [PORTS-1:0]          ready_q;
  logic [PORTS-1:0]          error_q;
  logic [PORTS*DATA_W-1:0]   rdata_q;
  logic                      bus_rw_q;
  logic                      bus_req_q;
  logic [ADDR_W-1:0]         bus_addr_q;
  logic [DATA_W-1:0]         bus_wdata_q;

  logic                      win_vld_d;
  logic [2:0]                win_d;
  logic [ADDR_W-1:0]         sel_addr_d;
  logic [DATA_W-1:0]         sel_wdata_d;
  logic                      sel_rw_d;
  logic                      req_g;

  // Position i of the scan order: plain index for fixed priority, rotated past last grant otherwise.
  function automatic int scan_pos(input int i, input logic [2:0] last);
    if (MODE == 0) return i;
    return (int'(last) + 1 + i) % PORTS;
  endfunction

  // Pick the winner: first requesting port in scan order.
  always_comb begin
    win_vld_d = 1'b0;
    win_d     = '0;
    for (int i = 0; i < PORTS; i++) begin
      for (int k = 0; k < PORTS; k++) begin
        if (!win_vld_d && i_request[k] && (scan_pos(i, last_q) == k)) begin
          win_vld_d = 1'b1;
          win_d     = 3'(k);
        end
      end
    end
  end

  // Route the winner's fields to the bus registers and look up the granted port's request.
  always_comb begin
    sel_addr_d  = '0;
    sel_wdata_d = '0;
    sel_rw_d    = 1'b0;
    req_g       = 1'b0;
    for (int k = 0; k < PORTS; k++) begin
      if (win_d == 3'(k)) begin
        sel_addr_d  = i_address[k*ADDR_W +: ADDR_W];
        sel_wdata_d = i_wdata[k*DATA_W +: DATA_W];
        sel_rw_d    = i_rw[k];
      end
      if (grant_q == 3'(k)) req_g = i_request[k];
    end
  end

  // IDLE -> BUS -> ACK -> IDLE handshake FSM with registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= 3'(PORTS - 1);
      cnt_q       <= '0;
      ready_q     <= '0;
      error_q     <= '0;
      rdata_q     <= '0;
      bus_rw_q    <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            bus_addr_q  <= sel_addr_d;
            bus_wdata_q <= sel_wdata_d;
            bus_rw_q    <= sel_rw_d;
            bus_req_q   <= 1'b1;
            grant_q     <= win_d;
            cnt_q       <= '0;
            state_q     <= BUS;
          end
        end
        BUS: begin
          if (i_bus_ready) begin
            bus_req_q <= 1'b0;
            for (int k = 0; k < PORTS; k++) begin
              if (grant_q == 3'(k)) begin
                rdata_q[k*DATA_W +: DATA_W] <= i_bus_rdata;
                ready_q[k]                  <= 1'b1;
                error_q[k]                  <= 1'b0;
              end
            end
            state_q <= ACK;
          end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
            // Slave never answered: complete with an error and all-ones data.
            bus_req_q <= 1'b0;
            for (int k = 0; k < PORTS; k++) begin
              if (grant_q == 3'(k)) begin
                rdata_q[k*DATA_W +: DATA_W] <= '1;
                ready_q[k]                  <= 1'b1;
                error_q[k]                  <= 1'b1;
              end
            end
            state_q <= ACK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ACK: begin
          // Four-phase close: both the master and the slave must have released.
          if (!req_g && !i_bus_ready) begin
            ready_q <= '0;
            error_q <= '0;
            last_q  <= grant_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready       = ready_q;
  assign o_error       = error_q;
  assign o_rdata       = rdata_q;
  assign o_bus_rw      = bus_rw_q;
  assign o_bus_request = bus_req_q;
  assign o_bus_address = bus_addr_q;
  assign o_bus_wdata   = bus_wdata_q;
  assign o_busy        = (state_q != IDLE);
  assign o_grant       = grant_q;

endmodule

// File: tb/tb_cpu_bus_arbiter_n.sv
// Purpose: directed self-checking bench for cpu_bus_arbiter_n (round-robin/timeout and fixed-priority instances).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: bench masters hold request one cycle after seeing o_ready; slaves are zero-wait or manual.
module tb_cpu_bus_arbiter_n;

  logic clk;
  logic i_reset;
  int   n_cmp;
  int   n_fail;
  int   cyc;

  // Instance A: 4 ports, round-robin, timeout 8.
  logic [3:0]   a_request, a_rw, a_want, a_rdy_prev, a_ready, a_error;
  logic [127:0] a_address, a_wdata, a_rdata;
  logic         a_bus_rw, a_bus_request, a_bus_ready, a_busy, a_auto;
  logic [31:0]  a_bus_address, a_bus_rdata, a_bus_wdata;
  logic [2:0]   a_grant;

  // Instance B: 3 ports, fixed priority, no timeout.
  logic [2:0]   b_request, b_rw, b_want, b_rdy_prev, b_ready, b_error;
  logic [95:0]  b_address, b_wdata, b_rdata;
  logic         b_bus_rw, b_bus_request, b_bus_ready, b_busy, b_auto;
  logic [31:0]  b_bus_address, b_bus_rdata, b_bus_wdata;
  logic [2:0]   b_grant;

  cpu_bus_arbiter_n #(.PORTS(4), .ADDR_W(32), .DATA_W(32), .MODE(1), .TIMEOUT(8)) dut_a (
    .i_clock(clk), .i_reset(i_reset),
    .i_request(a_request), .i_rw(a_rw), .i_address(a_address), .i_wdata(a_wdata),
    .o_ready(a_ready), .o_error(a_error), .o_rdata(a_rdata),
    .o_bus_rw(a_bus_rw), .o_bus_request(a_bus_request), .i_bus_ready(a_bus_ready),
    .o_bus_address(a_bus_address), .i_bus_rdata(a_bus_rdata), .o_bus_wdata(a_bus_wdata),
    .o_busy(a_busy), .o_grant(a_grant)
  );

  cpu_bus_arbiter_n #(.PORTS(3), .ADDR_W(32), .DATA_W(32), .MODE(0), .TIMEOUT(0)) dut_b (
    .i_clock(clk), .i_reset(i_reset),
    .i_request(b_request), .i_rw(b_rw), .i_address(b_address), .i_wdata(b_wdata),
    .o_ready(b_ready), .o_error(b_error), .o_rdata(b_rdata),
    .o_bus_rw(b_bus_rw), .o_bus_request(b_bus_request), .i_bus_ready(b_bus_ready),
    .o_bus_address(b_bus_address), .i_bus_rdata(b_bus_rdata), .o_bus_wdata(b_bus_wdata),
    .o_busy(b_busy), .o_grant(b_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One cycle: advance, then act as masters (drop request one cycle after ready) and slaves.
  task automatic tick();
    @(posedge clk);
    #1;
    a_request  = a_want & ~(a_ready & a_rdy_prev);
    a_rdy_prev = a_ready;
    b_request  = b_want & ~(b_ready & b_rdy_prev);
    b_rdy_prev = b_ready;
    if (a_auto) a_bus_ready = a_bus_request;
    if (b_auto) b_bus_ready = b_bus_request;
    cyc++;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    a_want = '0; a_request = '0; a_rdy_prev = '0; a_auto = 1'b1; a_bus_ready = 1'b0;
    b_want = '0; b_request = '0; b_rdy_prev = '0; b_auto = 1'b1; b_bus_ready = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  task automatic drain_a();
    for (int c = 0; c < 20 && a_busy; c++) tick();
  endtask

  task automatic drain_b();
    for (int c = 0; c < 20 && b_busy; c++) tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({a_ready, a_error, a_bus_request, a_bus_rw, a_busy, a_grant} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_a_ctrl got %h want 0", {a_ready, a_error, a_bus_request, a_bus_rw, a_busy, a_grant});
    end
    n_cmp++;
    if ({a_rdata, a_bus_address, a_bus_wdata} !== 192'h0) begin
      n_fail++;
      $display("FAIL reset_a_data got %h want 0", {a_rdata, a_bus_address, a_bus_wdata});
    end
    n_cmp++;
    if ({b_ready, b_bus_request, b_busy, b_grant} !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_b_ctrl got %h want 0", {b_ready, b_bus_request, b_busy, b_grant});
    end
  endtask

  task automatic test_single_read();
    do_reset();
    a_auto = 1'b0;
    a_address[32 +: 32] = 32'h0000_1000;
    a_rw = 4'b0000;
    a_bus_rdata = 32'hDEAD_BEEF;
    a_want = 4'b0010;
    a_request = 4'b0010;
    n_cmp++;
    if (a_bus_request !== 1'b0) begin n_fail++; $display("FAIL read_pre_req got %b want 0", a_bus_request); end
    tick();
    n_cmp++;
    if ({a_bus_request, a_grant, a_bus_rw, a_bus_address} !== {1'b1, 3'd1, 1'b0, 32'h0000_1000}) begin
      n_fail++;
      $display("FAIL read_grant got req=%b g=%0d rw=%b addr=%h want 1 1 0 00001000",
               a_bus_request, a_grant, a_bus_rw, a_bus_address);
    end
    tick();
    tick();
    n_cmp++;
    if ({a_bus_request, a_ready} !== 5'b1_0000) begin
      n_fail++; $display("FAIL read_wait got req=%b rdy=%b want 1 0000", a_bus_request, a_ready);
    end
    a_bus_ready = 1'b1;
    tick();
    n_cmp++;
    if ({a_ready, a_error, a_bus_request} !== 9'b0010_0000_0) begin
      n_fail++; $display("FAIL read_done got rdy=%b err=%b req=%b want 0010 0000 0", a_ready, a_error, a_bus_request);
    end
    n_cmp++;
    if (a_rdata[32 +: 32] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL read_data got %h want deadbeef", a_rdata[32 +: 32]);
    end
    a_bus_ready = 1'b0;
    tick();
    n_cmp++;
    if (a_ready !== 4'b0010) begin n_fail++; $display("FAIL read_hold got %b want 0010", a_ready); end
    a_want = 4'b0000;
    tick();
    n_cmp++;
    if ({a_ready, a_busy} !== 5'b0000_0) begin
      n_fail++; $display("FAIL read_release got rdy=%b busy=%b want 0000 0", a_ready, a_busy);
    end
    a_auto = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [2:0] g [6];
    int         t [6];
    int         ng;
    logic       prev;
    do_reset();
    ng = 0;
    prev = 1'b0;
    a_want = 4'hF;
    a_request = 4'hF;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      tick();
      if (a_bus_request && !prev) begin g[ng] = a_grant; t[ng] = cyc; ng++; end
      prev = a_bus_request;
    end
    n_cmp++;
    if (ng != 6) begin n_fail++; $display("FAIL rr_count got %0d want 6", ng); end
    for (int i = 0; i < ng; i++) begin
      n_cmp++;
      if (g[i] !== 3'(i % 4)) begin n_fail++; $display("FAIL rr_grant[%0d] got %0d want %0d", i, g[i], i % 4); end
    end
    for (int i = 1; i < ng; i++) begin
      n_cmp++;
      if (t[i] - t[i-1] != 4) begin n_fail++; $display("FAIL rr_spacing[%0d] got %0d want 4", i, t[i] - t[i-1]); end
    end
    a_want = 4'h0;
    drain_a();
    n_cmp++;
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rr_drain got busy=%b want 0", a_busy); end
  endtask

  task automatic test_fixed_priority();
    int   n0, n2, ng;
    logic prev;
    logic [2:0] last_g;
    do_reset();
    n0 = 0; n2 = 0; ng = 0; prev = 1'b0; last_g = '0;
    b_want = 3'b101;
    b_request = 3'b101;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (b_bus_request && !prev) begin
        if (b_grant == 3'd0) n0++;
        if (b_grant == 3'd2) n2++;
      end
      prev = b_bus_request;
    end
    n_cmp++;
    if (n0 != 6) begin n_fail++; $display("FAIL fp_port0 got %0d grants want 6", n0); end
    n_cmp++;
    if (n2 != 0) begin n_fail++; $display("FAIL fp_port2_starved got %0d grants want 0", n2); end
    b_want = 3'b100;
    b_request = 3'b100;
    for (int c = 0; c < 12 && ng == 0; c++) begin
      tick();
      if (b_bus_request && !prev) begin last_g = b_grant; ng++; end
      prev = b_bus_request;
    end
    n_cmp++;
    if (ng != 1 || last_g !== 3'd2) begin
      n_fail++; $display("FAIL fp_port2_after got n=%0d g=%0d want 1 2", ng, last_g);
    end
    b_want = 3'b000;
    drain_b();
  endtask

  task automatic test_no_timeout();
    b_auto = 1'b0;
    b_bus_ready = 1'b0;
    b_want = 3'b010;
    b_request = 3'b010;
    tick();
    for (int c = 0; c < 20; c++) tick();
    n_cmp++;
    if ({b_bus_request, b_grant, b_ready, b_error} !== {1'b1, 3'd1, 3'b000, 3'b000}) begin
      n_fail++; $display("FAIL nto_wait got req=%b g=%0d rdy=%b err=%b want 1 1 000 000",
                         b_bus_request, b_grant, b_ready, b_error);
    end
    b_bus_rdata = 32'hA5A5_0001;
    b_bus_ready = 1'b1;
    tick();
    n_cmp++;
    if ({b_ready, b_error, b_rdata[32 +: 32]} !== {3'b010, 3'b000, 32'hA5A5_0001}) begin
      n_fail++; $display("FAIL nto_done got rdy=%b err=%b data=%h want 010 000 a5a50001",
                         b_ready, b_error, b_rdata[32 +: 32]);
    end
    b_bus_ready = 1'b0;
    b_want = 3'b000;
    tick(); tick(); tick();
    n_cmp++;
    if ({b_busy, b_ready} !== 4'b0) begin n_fail++; $display("FAIL nto_idle got busy=%b rdy=%b want 0 000", b_busy, b_ready); end
    b_auto = 1'b1;
  endtask

  task automatic test_simultaneous();
    logic [2:0] g [2];
    int         ng;
    logic       prev;
    do_reset();
    a_want = 4'b0010;
    a_request = 4'b0010;
    for (int c = 0; c < 10 && !a_ready[1]; c++) tick();
    a_want = 4'b0000;
    drain_a();
    ng = 0; prev = 1'b0;
    a_want = 4'b1001;
    a_request = 4'b1001;
    for (int c = 0; c < 20 && ng < 2; c++) begin
      tick();
      if (a_bus_request && !prev) begin g[ng] = a_grant; ng++; end
      prev = a_bus_request;
    end
    n_cmp++;
    if (ng != 2 || g[0] !== 3'd3 || g[1] !== 3'd0) begin
      n_fail++; $display("FAIL simul_order got n=%0d g0=%0d g1=%0d want 2 3 0", ng, g[0], g[1]);
    end
    a_want = 4'b0000;
    drain_a();
  endtask

  task automatic test_timeout();
    int hi;
    a_auto = 1'b0;
    a_bus_ready = 1'b0;
    a_address[64 +: 32] = 32'hFFFF_0000;
    a_wdata[64 +: 32] = 32'h1234_5678;
    a_rw = 4'b0100;
    a_want = 4'b0100;
    a_request = 4'b0100;
    tick();
    n_cmp++;
    if ({a_bus_request, a_grant, a_bus_rw, a_bus_address, a_bus_wdata} !==
        {1'b1, 3'd2, 1'b1, 32'hFFFF_0000, 32'h1234_5678}) begin
      n_fail++; $display("FAIL to_start got req=%b g=%0d rw=%b addr=%h wd=%h want 1 2 1 ffff0000 12345678",
                         a_bus_request, a_grant, a_bus_rw, a_bus_address, a_bus_wdata);
    end
    a_address[64 +: 32] = 32'h0;
    a_wdata[64 +: 32] = 32'h0;
    hi = 1;
    while (a_bus_request && hi < 20) begin
      tick();
      if (a_bus_request) hi++;
    end
    n_cmp++;
    if (hi != 8) begin n_fail++; $display("FAIL to_cycles got %0d want 8", hi); end
    n_cmp++;
    if ({a_ready, a_error, a_rdata[64 +: 32]} !== {4'b0100, 4'b0100, 32'hFFFF_FFFF}) begin
      n_fail++; $display("FAIL to_result got rdy=%b err=%b data=%h want 0100 0100 ffffffff",
                         a_ready, a_error, a_rdata[64 +: 32]);
    end
    n_cmp++;
    if (a_bus_address !== 32'hFFFF_0000) begin
      n_fail++; $display("FAIL to_frozen got %h want ffff0000", a_bus_address);
    end
    a_want = 4'b0000;
    tick(); tick(); tick();
    n_cmp++;
    if ({a_ready, a_error, a_busy} !== 9'b0) begin
      n_fail++; $display("FAIL to_release got rdy=%b err=%b busy=%b want 0 0 0", a_ready, a_error, a_busy);
    end
    a_rw = 4'b0000;
    a_auto = 1'b1;
  endtask

  task automatic test_reset_mid();
    a_auto = 1'b0;
    a_bus_ready = 1'b0;
    a_want = 4'b1000;
    a_request = 4'b1000;
    tick();
    tick();
    n_cmp++;
    if ({a_bus_request, a_grant} !== {1'b1, 3'd3}) begin
      n_fail++; $display("FAIL rst_mid_bus got req=%b g=%0d want 1 3", a_bus_request, a_grant);
    end
    i_reset = 1'b1;
    tick();
    n_cmp++;
    if ({a_bus_request, a_ready, a_busy} !== 6'b0) begin
      n_fail++; $display("FAIL rst_mid_abort got req=%b rdy=%b busy=%b want 0 0000 0", a_bus_request, a_ready, a_busy);
    end
    i_reset = 1'b0;
    a_want = 4'b1001;
    a_request = 4'b1001;
    tick();
    n_cmp++;
    if ({a_bus_request, a_grant} !== {1'b1, 3'd0}) begin
      n_fail++; $display("FAIL rst_mid_first got req=%b g=%0d want 1 0", a_bus_request, a_grant);
    end
    a_want = 4'b0000;
    a_auto = 1'b1;
    a_bus_ready = 1'b1;
    drain_a();
    n_cmp++;
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_drain got busy=%b want 0", a_busy); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    i_reset = 1'b1;
    a_request = '0; a_rw = '0; a_want = '0; a_rdy_prev = '0; a_address = '0; a_wdata = '0;
    a_bus_ready = 1'b0; a_bus_rdata = '0; a_auto = 1'b1;
    b_request = '0; b_rw = '0; b_want = '0; b_rdy_prev = '0; b_address = '0; b_wdata = '0;
    b_bus_ready = 1'b0; b_bus_rdata = '0; b_auto = 1'b1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_no_timeout();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_bus_arbiter_n.md
Name: cpu_bus_arbiter_n

Overview:
- Parametrised N-port successor to the CPU's two-port bus access block.
- Arbitrates PORTS masters (fetch, memory, DMA, debug, ...) onto one shared CPU bus using the existing request/ready four-phase handshake.
- Selectable fixed-priority or round-robin arbitration.
- Optional bus timeout that returns an error instead of hanging the pipeline.

Parameters:
- PORTS, 2, number of master ports (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT, 0, cycles to wait for i_bus_ready before aborting; 0 disables timeout.

Ports:
- i_clock  in  1  the single clock for the block; all state changes on its rising edge.
- i_reset  in  1  reset; synchronous, active-high.
- i_request  in  PORTS  per-port request; held high until that port's o_ready is seen.
- i_rw  in  PORTS  per-port direction: 1 = write, 0 = read.
- i_address  in  PORTS*ADDR_W  per-port address; port k occupies bits [k*ADDR_W +: ADDR_W].
- i_wdata  in  PORTS*DATA_W  per-port write data; same packing as i_address.
- o_ready  out  PORTS  per-port completion; one-hot or zero.
- o_error  out  PORTS  per-port timeout flag; valid while o_ready is high.
- o_rdata  out  PORTS*DATA_W  per-port read data, registered.
- o_bus_rw  out  1  downstream direction.
- o_bus_request  out  1  downstream request.
- i_bus_ready  in  1  downstream ready.
- o_bus_address  out  ADDR_W  downstream address.
- i_bus_rdata  in  DATA_W  downstream read data.
- o_bus_wdata  out  DATA_W  downstream write data.
- o_busy  out  1  high in any state other than IDLE.
- o_grant  out  3  index of the current or last granted port.

Behaviour:
- Reset values: o_ready=0, o_error=0, o_rdata=0, o_bus_request=0, o_bus_rw=0, o_bus_address=0, o_bus_wdata=0, o_busy=0, o_grant=0, state=IDLE.
- Reset also sets the round-robin pointer last=PORTS-1 (port 0 wins first) and clears the timeout counter.
- Reset mid-transaction aborts immediately; no o_ready pulse is produced for the aborted transfer.
- States: IDLE, BUS, ACK.
- IDLE:
  - If any i_request bit is set, choose winner g.
  - MODE 0: g = lowest set index.
  - MODE 1: g = first set index scanning last+1, last+2, ..., wrapping modulo PORTS.
  - Register o_bus_address, o_bus_rw and o_bus_wdata from port g; set o_bus_request=1 and o_grant=g; go to BUS.
  - Request-to-bus latency is 1 cycle.
- BUS:
  - Downstream fields stay frozen; changes on port g's inputs are ignored until ACK exits.
  - Normal completion, when i_bus_ready=1:
    - o_bus_request<=0.
    - o_rdata[g]<=i_bus_rdata (also latched on writes; masters ignore it).
    - o_ready[g]<=1, o_error[g]<=0.
    - Go to ACK.
  - Timeout, when TIMEOUT>0 and the counter reaches TIMEOUT-1 without i_bus_ready:
    - o_bus_request<=0.
    - o_rdata[g]<=all ones.
    - o_ready[g]<=1, o_error[g]<=1.
    - Go to ACK.
  - The timeout counter is cleared on entry to BUS.
- ACK:
  - Hold o_ready[g] (and o_error[g]) until i_request[g]=0 and i_bus_ready=0 in the same cycle.
  - Then clear o_ready and o_error, set last<=g, go to IDLE.
  - A new grant can follow no earlier than the next cycle, giving a minimum of 4 cycles per transfer with a zero-wait slave.
- Requests from other ports raised during BUS or ACK are held pending; no preemption.
- A port dropping i_request during BUS is a protocol violation; the transfer still completes, and ACK exits once i_bus_ready is low.
- Round-robin fairness: with all PORTS requesting continuously, grants cycle 0,1,...,PORTS-1,0.
- Fixed priority may starve higher indices; this is intended.
- PORTS=1 degenerates to a registered pass-through with the same state machine.

Test Plan:
- Single read: PORTS=2, port1 requests read of 0x0000_1000; slave returns 0xDEAD_BEEF with 2 wait cycles. Required: o_bus_request rises 1 cycle after request, o_rdata[1]=0xDEAD_BEEF, o_ready=2'b10 until port1 drops request; o_error=0.
- Round-robin: MODE=1, PORTS=4, all four ports request continuously with a zero-wait slave. Required: o_grant sequence 0,1,2,3,0,1 and one transfer every 4 cycles.
- Fixed priority: MODE=0, ports 0 and 2 request continuously. Required: port 0 is granted every time and port 2 is never granted; port 2 is granted once port 0 idles.
- Simultaneous arrival: MODE=1, last=1, ports 0 and 3 raise request in the same cycle. Required: port 3 is granted first, then port 0.
- Timeout: TIMEOUT=8, write 0x1234_5678 to 0xFFFF_0000 with the slave never ready. Required: o_bus_request drops after 8 BUS cycles; o_ready[g]=1, o_error[g]=1, o_rdata[g]=0xFFFF_FFFF.
- Reset mid-transfer: assert i_reset during BUS. Required: next cycle o_bus_request=0, o_ready=0, o_busy=0, and port 0 wins the first grant after reset.
